hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode issue port and stall feedback between decode and the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(NREGS);

  logic              issue_valid;
  logic [RW-1:0]     issue_rs1;
  logic [RW-1:0]     issue_rs2;
  logic              issue_use_rs1;
  logic              issue_use_rs2;
  logic [RW-1:0]     issue_rd;
  logic              issue_load;
  logic              issue_store;
  logic [31:0]       issue_addr;
  logic              flush;
  logic              stall;
  logic [1:0]        stall_reason;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_load, issue_store, issue_addr, flush,
    input  stall, stall_reason, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_load, issue_store, issue_addr, flush,
    output stall, stall_reason, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use register scoreboard plus pending-store queue; stalls decode on hazards
module hazard_scoreboard #(
  parameter int NREGS      = 32,
  parameter int LOAD_LAT   = 3,
  parameter int SQ_DEPTH   = 4,
  parameter int STORE_LAT  = 2,
  parameter int MEM_HAZ_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int RW = $clog2(NREGS);
  localparam int IW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

  logic [3:0]          busyCnt [1:NREGS-1];
  logic [NREGS-1:0]    regBusy;
  logic [SQ_DEPTH-1:0] sqValid;
  logic [29:0]         sqAddr [SQ_DEPTH];
  logic [3:0]          sqCnt  [SQ_DEPTH];
  logic [CNT_W-1:0]    stallCnt;

  logic          regHaz;
  logic          memHaz;
  logic          fullHaz;
  logic          addrHit;
  logic          stallNow;
  logic [1:0]    reasonNow;
  logic          accept;
  logic [IW-1:0] freeIdx;

  // x0 stays permanently not-busy so a zero source never stalls
  always_comb begin
    regBusy = '0;
    for (int i = 1; i < NREGS; i++) begin
      regBusy[i] = (busyCnt[i] != 4'd0);
    end
  end

  always_comb begin
    addrHit = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (sqValid[i] && (sqAddr[i] == bus.issue_addr[31:2])) begin
        addrHit = 1'b1;
      end
    end
  end

  always_comb begin
    freeIdx = '0;
    for (int i = SQ_DEPTH - 1; i >= 0; i--) begin
      if (!sqValid[i]) begin
        freeIdx = IW'(i);
      end
    end
  end

  always_comb begin
    regHaz  = bus.issue_valid &&
              ((bus.issue_use_rs1 && regBusy[bus.issue_rs1]) ||
               (bus.issue_use_rs2 && regBusy[bus.issue_rs2]));
    memHaz  = (MEM_HAZ_EN != 0) && bus.issue_valid && bus.issue_load && addrHit;
    // an entry retiring this cycle is still counted as occupied
    fullHaz = bus.issue_valid && bus.issue_store && (&sqValid);
    stallNow = regHaz || memHaz || fullHaz;
    if (regHaz) begin
      reasonNow = 2'b01;
    end else if (memHaz) begin
      reasonNow = 2'b10;
    end else if (fullHaz) begin
      reasonNow = 2'b11;
    end else begin
      reasonNow = 2'b00;
    end
    accept = bus.issue_valid && !stallNow && !bus.flush;
  end

  assign bus.stall        = stallNow;
  assign bus.stall_reason = reasonNow;
  assign bus.stall_cnt    = stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        busyCnt[i] <= 4'd0;
      end
    end else if (bus.flush) begin
      for (int i = 1; i < NREGS; i++) begin
        busyCnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (accept && bus.issue_load && (bus.issue_rd == RW'(i))) begin
          busyCnt[i] <= 4'(LOAD_LAT);
        end else if (busyCnt[i] != 4'd0) begin
          busyCnt[i] <= busyCnt[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sqValid <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        sqAddr[i] <= '0;
        sqCnt[i]  <= 4'd0;
      end
    end else if (bus.flush) begin
      sqValid <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (sqValid[i]) begin
          sqCnt[i] <= sqCnt[i] - 4'd1;
          if (sqCnt[i] == 4'd1) begin
            sqValid[i] <= 1'b0;
          end
        end else if (accept && bus.issue_store && (freeIdx == IW'(i))) begin
          sqValid[i] <= 1'b1;
          sqAddr[i]  <= bus.issue_addr[31:2];
          sqCnt[i]   <= 4'(STORE_LAT);
        end
      end
    end
  end

  // flush deliberately leaves the performance counter alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stallNow && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed checks of register, memory and queue-full hazards, flush and reset
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n;

  logic        issueValid;
  logic [4:0]  issueRs1;
  logic [4:0]  issueRs2;
  logic        useRs1;
  logic        useRs2;
  logic [4:0]  issueRd;
  logic        issueLoad;
  logic        issueStore;
  logic [31:0] issueAddr;
  logic        flush;

  int checkCnt = 0;
  int passCnt  = 0;

  hazard_scoreboard_if #(.NREGS(32), .CNT_W(16)) busA ();
  hazard_scoreboard_if #(.NREGS(32), .CNT_W(16)) busB ();

  assign busA.issue_valid   = issueValid;
  assign busA.issue_rs1     = issueRs1;
  assign busA.issue_rs2     = issueRs2;
  assign busA.issue_use_rs1 = useRs1;
  assign busA.issue_use_rs2 = useRs2;
  assign busA.issue_rd      = issueRd;
  assign busA.issue_load    = issueLoad;
  assign busA.issue_store   = issueStore;
  assign busA.issue_addr    = issueAddr;
  assign busA.flush         = flush;

  assign busB.issue_valid   = issueValid;
  assign busB.issue_rs1     = issueRs1;
  assign busB.issue_rs2     = issueRs2;
  assign busB.issue_use_rs1 = useRs1;
  assign busB.issue_use_rs2 = useRs2;
  assign busB.issue_rd      = issueRd;
  assign busB.issue_load    = issueLoad;
  assign busB.issue_store   = issueStore;
  assign busB.issue_addr    = issueAddr;
  assign busB.flush         = flush;

  // dutA: defaults; dutB: memory check off and long store life so the queue can fill
  hazard_scoreboard #(.MEM_HAZ_EN(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  hazard_scoreboard #(.MEM_HAZ_EN(0), .STORE_LAT(6)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic st, input logic [31:0] addr);
    issueValid = v;
    issueRs1   = rs1;
    useRs1     = u1;
    issueRs2   = rs2;
    useRs2     = u2;
    issueRd    = rd;
    issueLoad  = ld;
    issueStore = st;
    issueAddr  = addr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 32'h100);
    #2;
    checkEq("rst_stall", 32'(busA.stall), 32'd0);
    checkEq("rst_reason", 32'(busA.stall_reason), 32'd0);
    checkEq("rst_cnt", 32'(busA.stall_cnt), 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    step();

    // load-use: one bubble after the load, then two stall cycles
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h200);
    #2 checkEq("ld5_issue", 32'(busA.stall), 32'd0);
    step();
    idle();
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd6, 1'b0, 1'b0, 32'h0);
    #2 checkEq("use5_stall0", 32'(busA.stall), 32'd1);
    checkEq("use5_reason0", 32'(busA.stall_reason), 32'd1);
    step();
    #2 checkEq("use5_stall1", 32'(busA.stall), 32'd1);
    checkEq("use5_reason1", 32'(busA.stall_reason), 32'd1);
    step();
    #2 checkEq("use5_free", 32'(busA.stall), 32'd0);
    checkEq("use5_reason2", 32'(busA.stall_reason), 32'd0);
    step();
    idle();
    #2 checkEq("use5_cnt", 32'(busA.stall_cnt), 32'd2);

    // x0 destination never tracked
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h240);
    #2 checkEq("ldx0_issue", 32'(busA.stall), 32'd0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
    #2 checkEq("usex0", 32'(busA.stall), 32'd0);
    step();

    // load after store to the same word
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100);
    #2 checkEq("st100_issue", 32'(busA.stall), 32'd0);
    step();
    idle();
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h102);
    #2 checkEq("ld102_stall", 32'(busA.stall), 32'd1);
    checkEq("ld102_reason", 32'(busA.stall_reason), 32'd2);
    checkEq("ld102_nomemhaz", 32'(busB.stall), 32'd0);
    step();
    #2 checkEq("ld102_free", 32'(busA.stall), 32'd0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h104);
    #2 checkEq("ld104_nostall", 32'(busA.stall), 32'd0);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // queue full on dutB: four stores live for six cycles
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h300 + 32'(4 * k));
      #2 checkEq("sq_fill", 32'(busB.stall), 32'd0);
      step();
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h400);
    for (int k = 0; k < 3; k++) begin
      #2 checkEq("sq_full_stall", 32'(busB.stall), 32'd1);
      checkEq("sq_full_reason", 32'(busB.stall_reason), 32'd3);
      step();
    end
    #2 checkEq("sq_full_free", 32'(busB.stall), 32'd0);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // flush while a dependent instruction stalls
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'h500);
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    #2 checkEq("fl_pre_stall", 32'(busA.stall), 32'd1);
    step();
    flush = 1'b0;
    #2 checkEq("fl_post_stall", 32'(busA.stall), 32'd0);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 32'h500);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd12, 1'b0, 1'b0, 32'h0);
    #2 checkEq("fl_ld_dropped", 32'(busA.stall), 32'd0);
    step();

    // asynchronous reset with x5 busy and dutB queue full
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h700 + 32'(4 * k));
      step();
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h600);
    step();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h800);
    #1 checkEq("ar_pre_full", 32'(busB.stall_reason), 32'd3);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0, 32'h0);
    #1 checkEq("ar_pre_reg", 32'(busA.stall_reason), 32'd1);
    rst_n = 1'b0;
    #1 checkEq("ar_reg_clear", 32'(busA.stall), 32'd0);
    checkEq("ar_cnt_clear", 32'(busA.stall_cnt), 32'd0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h800);
    #1 checkEq("ar_sq_clear", 32'(busB.stall), 32'd0);
    rst_n = 1'b1;
    idle();
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0, 32'h0);
    #2 checkEq("ar_dep_ok", 32'(busA.stall), 32'd0);
    step();
    idle();
    #2 checkEq("ar_cnt_a", 32'(busA.stall_cnt), 32'd0);
    checkEq("ar_cnt_b", 32'(busB.stall_cnt), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
